sparkle_alz_seq: RTL and testbench

SPARKLE_ALZ_SEQ -- requirements
Module: sparkle_alz_seq

---
 rtl/sparkle_alz_seq_if.sv | 19 +
 rtl/sparkle_alz_seq.sv | 183 ++++++++++++++++++
 tb/tb_sparkle_alz_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sparkle_alz_seq_if.sv
// Branch load / result drain stream bundle for sparkle_alz_seq.
interface sparkle_alz_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sparkle_alz_seq.sv
// Sparkle ARX-layer sequencer: loads nb branches, runs one Alzette box per
// branch (forward or inverse, with step-constant injection), drains results.
package sparkle_alz_pkg;
  // Sparkle round constants, also used as the per-branch Alzette constant.
  function automatic logic [31:0] rcon(input logic [2:0] i);
    case (i)
      3'd0:    rcon = 32'hB7E15162;
      3'd1:    rcon = 32'hBF715880;
      3'd2:    rcon = 32'h38B4DA56;
      3'd3:    rcon = 32'h324E7738;
      3'd4:    rcon = 32'hBB1185EB;
      3'd5:    rcon = 32'h4F7C7B57;
      3'd6:    rcon = 32'hCFBFA1C8;
      default: rcon = 32'hC2B3293D;
    endcase
  endfunction
endpackage

// Single-cycle Alzette box. rs1 = {y, x}, imm selects the round constant,
// op_enc = 1 runs the forward box, 0 the exact inverse.
module alzette_ise_v4
  import sparkle_alz_pkg::*;
(
  input  logic [63:0] rs1,
  input  logic [2:0]  imm,
  input  logic        op_enc,
  output logic [63:0] rd
);
  logic [31:0] x, y, c;

  function automatic logic [31:0] ror(input logic [31:0] v, input int n);
    ror = (v >> n) | (v << (32 - n));
  endfunction

  // Four ARX rounds, unrolled; inverse undoes them in reverse order.
  always_comb begin
    c = rcon(imm);
    x = rs1[31:0];
    y = rs1[63:32];
    if (op_enc) begin
      x = x + ror(y, 31); y = y ^ ror(x, 24); x = x ^ c;
      x = x + ror(y, 17); y = y ^ ror(x, 17); x = x ^ c;
      x = x + y;          y = y ^ ror(x, 31); x = x ^ c;
      x = x + ror(y, 24); y = y ^ ror(x, 16); x = x ^ c;
    end else begin
      x = x ^ c; y = y ^ ror(x, 16); x = x - ror(y, 24);
      x = x ^ c; y = y ^ ror(x, 31); x = x - y;
      x = x ^ c; y = y ^ ror(x, 17); x = x - ror(y, 17);
      x = x ^ c; y = y ^ ror(x, 24); x = x - ror(y, 31);
    end
    rd = {y, x};
  end
endmodule

module sparkle_alz_seq
  import sparkle_alz_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         cfg_nb,
  input  logic               cfg_dec,
  input  logic [31:0]        cfg_step,
  sparkle_alz_seq_if.slave   bus,
  output logic               busy,
  output logic               done,
  output logic               err
);
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

  state_t      state, state_d;
  logic [2:0]  idx, idx_d;
  logic [3:0]  nb_q;
  logic        dec_q;
  logic [31:0] step_q;
  logic        err_q;
  logic [63:0] branch_buf [8];

  logic        last, nb_ok, buf_we;
  logic [63:0] buf_wdata, cur, dp_rs1, dp_rd, wb;
  logic [31:0] k, mask;
  logic        in_ready, out_valid;

  assign nb_ok = (cfg_nb != 4'd0) && (cfg_nb <= 4'd8);
  assign last  = ({1'b0, idx} == (nb_q - 4'd1));
  assign cur   = branch_buf[idx];

  // Step injection touches y of branch 0 (round constant) and branch 1 (step).
  assign k      = rcon(step_q[2:0]);
  assign mask   = (idx == 3'd0) ? k : (idx == 3'd1) ? step_q : 32'h0;
  assign dp_rs1 = {cur[63:32] ^ (dec_q ? 32'h0 : mask), cur[31:0]};
  assign wb     = {dp_rd[63:32] ^ (dec_q ? mask : 32'h0), dp_rd[31:0]};

  alzette_ise_v4 u_alz (
    .rs1    (dp_rs1),
    .imm    (idx),
    .op_enc (~dec_q),
    .rd     (dp_rd)
  );

  // Next-state, index and handshake decode.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    buf_we    = 1'b0;
    buf_wdata = bus.in_data;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start && nb_ok) begin
          state_d = LOAD;
          idx_d   = 3'd0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          buf_we = 1'b1;
          idx_d  = idx + 3'd1;
          if (last) begin
            idx_d   = 3'd0;
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        buf_we    = 1'b1;
        buf_wdata = wb;
        idx_d     = idx + 3'd1;
        if (last) begin
          idx_d   = 3'd0;
          state_d = DRAIN;
        end
      end
      default: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          idx_d = idx + 3'd1;
          if (last) begin
            done    = 1'b1;
            idx_d   = 3'd0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // State, index and reject-pulse registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 3'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      err_q <= (state == IDLE) && start && !nb_ok;
    end
  end

  // Job configuration, captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && start && nb_ok) begin
      nb_q   <= cfg_nb;
      dec_q  <= cfg_dec;
      step_q <= cfg_step;
    end
  end

  // Branch buffer: loaded in LOAD, updated in place during COMPUTE.
  always_ff @(posedge clk) begin
    if (!rst && buf_we) branch_buf[idx] <= buf_wdata;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = cur;
  assign busy          = (state != IDLE);
  assign err           = err_q;
endmodule

// File: tb/tb_sparkle_alz_seq.sv
// Randomized bench for sparkle_alz_seq against a behavioural Sparkle ARX model.
module tb_sparkle_alz_seq;
  logic        clk = 1'b0;
  logic        rst, start, cfg_dec, busy, done, err;
  logic [3:0]  cfg_nb;
  logic [31:0] cfg_step;

  sparkle_alz_seq_if bus();

  sparkle_alz_seq dut (
    .clk(clk), .rst(rst), .start(start), .cfg_nb(cfg_nb), .cfg_dec(cfg_dec),
    .cfg_step(cfg_step), .bus(bus), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int passes = 0, checks = 0;
  int done_cnt = 0, err_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] out_log[$];
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;

  logic [31:0] RCON [8] = '{32'hB7E15162, 32'hBF715880, 32'h38B4DA56, 32'h324E7738,
                            32'hBB1185EB, 32'h4F7C7B57, 32'hCFBFA1C8, 32'hC2B3293D};
  int RA [4] = '{31, 17, 0, 24};
  int RB [4] = '{24, 17, 31, 16};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  function automatic logic [63:0] alz(input logic [63:0] w, input logic [31:0] c, input bit inv);
    logic [31:0] x = w[31:0], y = w[63:32];
    if (!inv)
      for (int r = 0; r < 4; r++) begin
        x = x + rotr(y, RA[r]); y = y ^ rotr(x, RB[r]); x = x ^ c;
      end
    else
      for (int r = 3; r >= 0; r--) begin
        x = x ^ c; y = y ^ rotr(x, RB[r]); x = x - rotr(y, RA[r]);
      end
    return {y, x};
  endfunction

  // Sparkle ARX layer on nb branches with step injection on branches 0/1.
  task automatic model_job(input int nb, input bit dec, input logic [31:0] step,
                           input logic [63:0] w[8], output logic [63:0] r[8]);
    logic [31:0] inj;
    for (int i = 0; i < 8; i++) begin
      r[i] = w[i];
      inj = (i == 0) ? RCON[step % 8] : (i == 1) ? step : 32'h0;
      if (i < nb) begin
        if (!dec) r[i] = alz({w[i][63:32] ^ inj, w[i][31:0]}, RCON[i], 1'b0);
        else begin
          r[i] = alz(w[i], RCON[i], 1'b1);
          r[i][63:32] = r[i][63:32] ^ inj;
        end
      end
    end
  endtask

  // Output monitor: data against model, stall stability, done placement.
  always @(negedge clk) begin
    if (err)  err_cnt++;
    if (done) done_cnt++;
    if (prev_stall && bus.out_valid) chk("stall_hold", bus.out_data, prev_data);
    if (bus.out_valid && bus.out_ready) begin
      out_log.push_back(bus.out_data);
      if (exp_q.size() == 0) chk("unexpected_out", {63'd0, bus.out_valid}, 64'd0);
      else begin
        chk("out_data", bus.out_data, exp_q[0]);
        chk("done_on_hs", {63'd0, done}, {63'd0, exp_q.size() == 1});
        exp_q.delete(0);
      end
    end else if (done) chk("done_no_hs", {63'd0, done}, 64'd0);
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_words(input int nb, input bit dec, input logic [31:0] step,
                            input logic [63:0] w[8]);
    start = 1'b1; cfg_nb = 4'(nb); cfg_dec = dec; cfg_step = step;
    tick();
    start = 1'b0; cfg_nb = 4'($urandom); cfg_dec = 1'($urandom); cfg_step = $urandom;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(0, 3) == 0) begin bus.in_valid = 1'b0; tick(); end
      bus.in_valid = 1'b1; bus.in_data = w[i];
      chk("in_ready_load", {63'd0, bus.in_ready}, 64'd1);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_job(input int nb, input bit dec, input logic [31:0] step,
                         input logic [63:0] w[8], input bit stall, output logic [63:0] res[8]);
    logic [63:0] e[8];
    int k, d0;
    model_job(nb, dec, step, w, e);
    out_log.delete();
    d0 = done_cnt;
    bus.out_ready = 1'b0;
    load_words(nb, dec, step, w);
    for (int i = 0; i < nb; i++) exp_q.push_back(e[i]);
    k = 1;
    while (!bus.out_valid && k < 50) begin
      chk("in_ready_low", {63'd0, bus.in_ready}, 64'd0);
      tick(); k++;
    end
    chk("latency", 64'(k), 64'(nb + 1));
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      bus.out_ready = stall ? 1'($urandom) : 1'b1;
      tick(); k++;
    end
    if (k >= 300) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    bus.out_ready = 1'b0;
    chk("busy_end", {63'd0, busy}, 64'd0);
    chk("handshakes", 64'(out_log.size()), 64'(nb));
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    for (int i = 0; i < 8; i++) res[i] = (i < out_log.size()) ? out_log[i] : 64'd0;
  endtask

  task automatic rand_words(output logic [63:0] w[8]);
    for (int i = 0; i < 8; i++) w[i] = {$urandom, $urandom};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] w[8], r[8], b[8];
    int nbs[3] = '{1, 2, 8};
    int e0, d0;
    rst = 1'b1; start = 1'b0; cfg_nb = 4'd0; cfg_dec = 1'b0; cfg_step = 32'd0;
    bus.in_valid = 1'b0; bus.in_data = 64'd0; bus.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy",      {63'd0, busy},          64'd0);
    chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_done",      {63'd0, done},          64'd0);
    chk("rst_err",       {63'd0, err},           64'd0);

    // Model pins: inverse box undoes forward box; nb=4 latency is 5 cycles.
    w[0] = 64'h0123456789ABCDEF;
    chk("model_roundtrip", alz(alz(w[0], RCON[3], 1'b0), RCON[3], 1'b1), 64'h0123456789ABCDEF);

    rand_words(w);
    run_job(4, 1'b0, 32'd0, w, 1'b0, r);

    // Forward then inverse recovers the original words.
    foreach (nbs[j]) begin
      logic [31:0] st = $urandom;
      rand_words(w);
      run_job(nbs[j], 1'b0, st, w, 1'b0, r);
      run_job(nbs[j], 1'b1, st, r, 1'b1, b);
      for (int i = 0; i < nbs[j]; i++) chk("roundtrip", b[i], w[i]);
    end

    // Illegal branch counts are rejected with a single err pulse.
    e0 = err_cnt;
    for (int t = 0; t < 2; t++) begin
      start = 1'b1; cfg_nb = (t == 0) ? 4'd0 : 4'd9;
      tick();
      start = 1'b0;
      chk("err_pulse",    {63'd0, err},          64'd1);
      chk("err_busy",     {63'd0, busy},         64'd0);
      chk("err_in_ready", {63'd0, bus.in_ready}, 64'd0);
      tick();
      chk("err_clear",    {63'd0, err},          64'd0);
    end
    chk("err_count", 64'(err_cnt - e0), 64'd2);

    // nb=8 with random back-pressure.
    rand_words(w);
    run_job(8, 1'b0, $urandom, w, 1'b1, r);

    // step=9, nb=1: K = BF715880 on branch 0, step XOR skipped.
    rand_words(w);
    run_job(1, 1'b0, 32'd9, w, 1'b0, r);
    chk("step9_lit", r[0], alz({w[0][63:32] ^ 32'hBF715880, w[0][31:0]}, 32'hB7E15162, 1'b0));

    // Reset in the 2nd COMPUTE cycle, with an out-of-IDLE start that must be ignored.
    rand_words(w);
    d0 = done_cnt; e0 = err_cnt;
    bus.out_ready = 1'b1;
    load_words(4, 1'b0, 32'd5, w);
    start = 1'b1; cfg_nb = 4'd0;
    tick();
    start = 1'b0;
    chk("start_ignored_err", {63'd0, err}, 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",      {63'd0, busy},          64'd0);
    chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("abort_in_ready",  {63'd0, bus.in_ready},  64'd0);
    chk("abort_done",      {63'd0, done},          64'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_no_err",  64'(err_cnt - e0),  64'd0);
    rand_words(w);
    run_job(2, 1'b0, $urandom, w, 1'b0, r);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
